// File: rtl/conv_pool_pkg.sv
// -----------------------------------------------------------------------------
// conv_pool_pkg
// Shared types and constants for the conv_pool result path.
//   NUM_CH          number of conv_pool result channels
//   ADDR_W / DATA_W width of a result address / result byte
//   result_entry_t  one queued result {addr, data}
//   ch_idx_t        channel index, also the top bits of the SRAM address
//   next_ch()       round-robin successor of a channel index
// -----------------------------------------------------------------------------
package conv_pool_pkg;

    localparam int NUM_CH = 3;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } result_entry_t;

    typedef logic [1:0] ch_idx_t;

    function automatic ch_idx_t next_ch(input ch_idx_t ch);
        return (ch == ch_idx_t'(NUM_CH - 1)) ? ch_idx_t'(0) : ch + ch_idx_t'(1);
    endfunction

endpackage

// File: rtl/result_fifo.sv
// -----------------------------------------------------------------------------
// result_fifo
// Synchronous show-ahead FIFO holding queued result entries for one channel.
//   clk    in   rising-edge clock
//   rst    in   synchronous active-low reset (flushes pointers)
//   push   in   store din this edge (ignored when full unless popping too)
//   pop    in   drop the head entry this edge (ignored when empty)
//   din    in   entry to store
//   dout   out  head entry, valid whenever empty==0
//   full   out  DEPTH entries stored
//   empty  out  no entries stored
// A push into a full FIFO on the same edge as a pop is accepted: the write
// lands in the slot being vacated, and dout still shows the old head
// until the edge.
// -----------------------------------------------------------------------------
module result_fifo
    import conv_pool_pkg::*;
#(
    parameter int  DEPTH   = 8,
    parameter type entry_t = result_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  logic   pop,
    input  entry_t din,
    output entry_t dout,
    output logic   full,
    output logic   empty
);

    localparam int PTR_W = $clog2(DEPTH);

    // One extra pointer bit separates full from empty when the indices match.
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    entry_t         store [DEPTH];
    logic           push_ok;
    logic           pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = store[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                store[wr_ptr[PTR_W-1:0]] <= din;
                wr_ptr                   <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pool_result_collector.sv
// -----------------------------------------------------------------------------
// pool_result_collector
// Memory-side responder for the three conv_pool result write channels.
// Each channel's writes are queued in its own result_fifo; a round-robin
// arbiter moves one entry per cycle into a registered single-port SRAM write.
//
// Ports
//   clk                    in   rising-edge clock
//   rst                    in   synchronous active-low reset
//   we_k / addr_k / y_k    in   result strobe, address, byte for channel k
//   mem_we                 out  SRAM write enable (registered)
//   mem_addr               out  SRAM address {channel, addr} (registered)
//   mem_wdata              out  SRAM write data (registered)
//   overflow               out  sticky per-channel dropped-write flag
//   busy                   out  any FIFO holds data or a write is on the port
//   done                   out  sticky frame-complete flag
//   commit_cnt_k           out  saturating count of results committed, ch k
//   checksum_k             out  (RESULT_CHECKSUM_EN only) mod-2^16 sum of
//                               committed bytes for channel k
//
// Build option: define RESULT_CHECKSUM_EN to add the checksum_k ports.
// -----------------------------------------------------------------------------
module pool_result_collector
    import conv_pool_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int EXPECTED = 65536,
    parameter int CNT_W    = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_0,
    input  logic             we_1,
    input  logic             we_2,
    input  logic [15:0]      addr_0,
    input  logic [15:0]      addr_1,
    input  logic [15:0]      addr_2,
    input  logic [7:0]       y_0,
    input  logic [7:0]       y_1,
    input  logic [7:0]       y_2,
    output logic             mem_we,
    output logic [17:0]      mem_addr,
    output logic [7:0]       mem_wdata,
    output logic [2:0]       overflow,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] commit_cnt_0,
    output logic [CNT_W-1:0] commit_cnt_1,
    output logic [CNT_W-1:0] commit_cnt_2
`ifdef RESULT_CHECKSUM_EN
    ,
    output logic [15:0]      checksum_0,
    output logic [15:0]      checksum_1,
    output logic [15:0]      checksum_2
`endif
);

    localparam logic [CNT_W-1:0] EXPECTED_C = CNT_W'(EXPECTED);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    logic [NUM_CH-1:0] we_vec;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] pop;
    result_entry_t     din  [NUM_CH];
    result_entry_t     dout [NUM_CH];

    ch_idx_t           rr_ptr;      // first channel the next search looks at
    ch_idx_t           cand;
    ch_idx_t           grant_idx;
    logic              grant_valid;
    result_entry_t     grant_entry;

    logic [CNT_W-1:0]  cnt [NUM_CH];
    logic              cnt_reached_all;
    logic              all_empty;

    // ---------------------------------------------------------------- inputs
    assign we_vec = {we_2, we_1, we_0};
    assign din[0] = '{addr: addr_0, data: y_0};
    assign din[1] = '{addr: addr_1, data: y_1};
    assign din[2] = '{addr: addr_2, data: y_2};

    // ----------------------------------------------------------------- FIFOs
    for (genvar k = 0; k < NUM_CH; k++) begin : g_fifo
        result_fifo #(
            .DEPTH   (DEPTH),
            .entry_t (result_entry_t)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (we_vec[k]),
            .pop   (pop[k]),
            .din   (din[k]),
            .dout  (dout[k]),
            .full  (full[k]),
            .empty (empty[k])
        );
    end

    // ------------------------------------------------------------- arbiter
    // Walk the channels starting at rr_ptr; the first non-empty one wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = rr_ptr;
        cand        = rr_ptr;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!grant_valid && !empty[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
            cand = next_ch(cand);
        end
    end

    always_comb begin
        pop         = '0;
        grant_entry = dout[0];
        for (int k = 0; k < NUM_CH; k++) begin
            if (grant_valid && (grant_idx == ch_idx_t'(k))) begin
                pop[k]      = 1'b1;
                grant_entry = dout[k];
            end
        end
    end

    // ------------------------------------------------------ output register
    // Address and data hold their last value when idle; only mem_we drops.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rr_ptr    <= '0;
        end else begin
            mem_we <= grant_valid;
            if (grant_valid) begin
                mem_addr  <= {grant_idx, grant_entry.addr};
                mem_wdata <= grant_entry.data;
                rr_ptr    <= next_ch(grant_idx);
            end
        end
    end

    // ------------------------------------------------------ commit counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (pop[k] && (cnt[k] != CNT_MAX)) begin
                    cnt[k] <= cnt[k] + 1'b1;
                end
            end
        end
    end

    assign commit_cnt_0 = cnt[0];
    assign commit_cnt_1 = cnt[1];
    assign commit_cnt_2 = cnt[2];

    // ------------------------------------------------------------- overflow
    // A write is lost only when its FIFO is full and not draining this edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow <= '0;
        end else begin
            overflow <= overflow | (we_vec & full & ~pop);
        end
    end

    // ---------------------------------------------------------- done / busy
    always_comb begin
        cnt_reached_all = 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (cnt[k] < EXPECTED_C) begin
                cnt_reached_all = 1'b0;
            end
        end
    end

    assign all_empty = &empty;
    assign busy      = !all_empty || mem_we;

    // Waiting for mem_we to drop means the last write has reached the SRAM.
    always_ff @(posedge clk) begin
        if (!rst) begin
            done <= 1'b0;
        end else if (cnt_reached_all && all_empty && !mem_we) begin
            done <= 1'b1;
        end
    end

`ifdef RESULT_CHECKSUM_EN
    // ------------------------------------------------------------ checksums
    logic [15:0] csum [NUM_CH];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                csum[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (pop[k]) begin
                    csum[k] <= csum[k] + 16'(dout[k].data);
                end
            end
        end
    end

    assign checksum_0 = csum[0];
    assign checksum_1 = csum[1];
    assign checksum_2 = csum[2];
`endif

endmodule

// File: tb/tb_pool_result_collector.sv
// -----------------------------------------------------------------------------
// tb_pool_result_collector
// Self-checking bench for pool_result_collector (EXPECTED overridden to 4).
// A queue-based reference model tracks per-channel backlogs, the round-robin
// turn and the expected SRAM write stream; each test task drives stimulus and
// checks the DUT inline against the model or against fixed expectations.
// -----------------------------------------------------------------------------
module tb_pool_result_collector;

    localparam int DEPTH   = 8;
    localparam int EXP     = 4;
    localparam int CNT_W   = 17;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic        clk_tb = 1'b0;
    logic        rst    = 1'b0;
    logic        we_0 = 1'b0, we_1 = 1'b0, we_2 = 1'b0;
    logic [15:0] addr_0 = '0, addr_1 = '0, addr_2 = '0;
    logic [7:0]  y_0 = '0, y_1 = '0, y_2 = '0;
    logic        mem_we;
    logic [17:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [2:0]  overflow;
    logic        busy;
    logic        done;
    logic [CNT_W-1:0] commit_cnt_0, commit_cnt_1, commit_cnt_2;
`ifdef RESULT_CHECKSUM_EN
    logic [15:0] checksum_0, checksum_1, checksum_2;
`endif

    int vec = 0;
    int err = 0;

    always #5 clk_tb = ~clk_tb;

    pool_result_collector #(
        .DEPTH    (DEPTH),
        .EXPECTED (EXP),
        .CNT_W    (CNT_W)
    ) dut (
        .clk          (clk_tb),
        .rst          (rst),
        .we_0         (we_0),
        .we_1         (we_1),
        .we_2         (we_2),
        .addr_0       (addr_0),
        .addr_1       (addr_1),
        .addr_2       (addr_2),
        .y_0          (y_0),
        .y_1          (y_1),
        .y_2          (y_2),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .overflow     (overflow),
        .busy         (busy),
        .done         (done),
        .commit_cnt_0 (commit_cnt_0),
        .commit_cnt_1 (commit_cnt_1),
        .commit_cnt_2 (commit_cnt_2)
`ifdef RESULT_CHECKSUM_EN
        ,
        .checksum_0   (checksum_0),
        .checksum_1   (checksum_1),
        .checksum_2   (checksum_2)
`endif
    );

    // ------------------------------------------------------ reference model
    logic [23:0] mq [3][$];
    int          m_rr;
    logic        m_we;
    logic [17:0] m_addr;
    logic [7:0]  m_data;
    int          m_cnt [3];
    logic [15:0] m_csum [3];
    logic [2:0]  m_ovf;
    logic        m_done;
    int          m_drops;

    function automatic int pick();
        int c;
        for (int i = 0; i < 3; i++) begin
            c = (m_rr + i) % 3;
            if (mq[c].size() != 0) return c;
        end
        return -1;
    endfunction

    function automatic logic model_busy();
        return m_we || (mq[0].size() != 0) || (mq[1].size() != 0) || (mq[2].size() != 0);
    endfunction

    always @(posedge clk_tb) begin
        logic [2:0]  w;
        logic [15:0] a [3];
        logic [7:0]  y [3];
        logic [23:0] e;
        logic        done_now;
        int          g;
        w = {we_2, we_1, we_0};
        a[0] = addr_0; a[1] = addr_1; a[2] = addr_2;
        y[0] = y_0;    y[1] = y_1;    y[2] = y_2;
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                mq[k].delete();
                m_cnt[k]  = 0;
                m_csum[k] = '0;
            end
            m_rr = 0; m_we = 1'b0; m_addr = '0; m_data = '0;
            m_ovf = '0; m_done = 1'b0; m_drops = 0;
        end else begin
            done_now = (m_cnt[0] >= EXP) && (m_cnt[1] >= EXP) && (m_cnt[2] >= EXP) &&
                       (mq[0].size() == 0) && (mq[1].size() == 0) && (mq[2].size() == 0) && !m_we;
            g = pick();
            if (g >= 0) begin
                e      = mq[g].pop_front();
                m_we   = 1'b1;
                m_addr = {2'(g), e[23:8]};
                m_data = e[7:0];
                if (m_cnt[g] < CNT_MAX) m_cnt[g]++;
                m_csum[g] = m_csum[g] + 16'(e[7:0]);
                m_rr = (g + 1) % 3;
            end else begin
                m_we = 1'b0;
            end
            for (int k = 0; k < 3; k++) begin
                if (w[k]) begin
                    if (mq[k].size() < DEPTH) mq[k].push_back({a[k], y[k]});
                    else begin m_ovf[k] = 1'b1; m_drops++; end
                end
            end
            if (done_now) m_done = 1'b1;
        end
    end

    // -------------------------------------------------------------- helpers
    task automatic drive(input logic [2:0] w, input logic [15:0] a0, input logic [15:0] a1,
                         input logic [15:0] a2, input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] d2);
        we_0 = w[0]; we_1 = w[1]; we_2 = w[2];
        addr_0 = a0; addr_1 = a1; addr_2 = a2;
        y_0 = d0; y_1 = d1; y_2 = d2;
    endtask

    task automatic do_reset();
        drive(3'b000, 16'h0, 16'h0, 16'h0, 8'h0, 8'h0, 8'h0);
        rst = 1'b0;
        @(negedge clk_tb);
        @(negedge clk_tb);
        rst = 1'b1;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(3'b111, 16'(i), 16'(i), 16'(i), 8'(i), 8'(i), 8'(i));
            @(negedge clk_tb);
        end
        drive(3'b000, 16'h0, 16'h0, 16'h0, 8'h0, 8'h0, 8'h0);
        rst = 1'b0;
        @(negedge clk_tb);
        @(negedge clk_tb);
        vec++; if (mem_we !== 1'b0) begin err++; $display("FAIL reset_mem_we got %0b expected 0", mem_we); end
        vec++; if (mem_addr !== 18'h0 || mem_wdata !== 8'h0) begin err++; $display("FAIL reset_mem_bus got %05h/%02h expected 00000/00", mem_addr, mem_wdata); end
        vec++; if (overflow !== 3'b000) begin err++; $display("FAIL reset_overflow got %03b expected 000", overflow); end
        vec++; if (busy !== 1'b0 || done !== 1'b0) begin err++; $display("FAIL reset_busy_done got %0b%0b expected 00", busy, done); end
        vec++; if ({commit_cnt_0, commit_cnt_1, commit_cnt_2} !== '0) begin err++; $display("FAIL reset_counts got %0d %0d %0d expected 0 0 0", commit_cnt_0, commit_cnt_1, commit_cnt_2); end
        rst = 1'b1;
    endtask

    task automatic test_single_write();
        do_reset();
        drive(3'b001, 16'h0005, 16'h0, 16'h0, 8'hA5, 8'h0, 8'h0);
        @(negedge clk_tb);
        drive(3'b000, 16'h0, 16'h0, 16'h0, 8'h0, 8'h0, 8'h0);
        vec++; if (mem_we !== 1'b0 || busy !== 1'b1) begin err++; $display("FAIL single_queued got we=%0b busy=%0b expected we=0 busy=1", mem_we, busy); end
        @(negedge clk_tb);
        vec++; if (mem_we !== 1'b1 || mem_addr !== 18'h00005 || mem_wdata !== 8'hA5) begin
            err++; $display("FAIL single_commit got %0b/%05h/%02h expected 1/00005/a5", mem_we, mem_addr, mem_wdata); end
        vec++; if (commit_cnt_0 !== 17'd1) begin err++; $display("FAIL single_cnt got %0d expected 1", commit_cnt_0); end
        @(negedge clk_tb);
        vec++; if (mem_we !== 1'b0 || busy !== 1'b0) begin err++; $display("FAIL single_idle got we=%0b busy=%0b expected 0 0", mem_we, busy); end
    endtask

    task automatic test_three();
        logic [17:0] ea [3];
        logic [7:0]  ed [3];
        ea[0] = 18'h00001; ea[1] = 18'h10002; ea[2] = 18'h20003;
        ed[0] = 8'h11;     ed[1] = 8'h22;     ed[2] = 8'h33;
        do_reset();
        drive(3'b111, 16'h1, 16'h2, 16'h3, 8'h11, 8'h22, 8'h33);
        @(negedge clk_tb);
        drive(3'b000, 16'h0, 16'h0, 16'h0, 8'h0, 8'h0, 8'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_tb);
            vec++; if (mem_we !== 1'b1 || mem_addr !== ea[i] || mem_wdata !== ed[i]) begin
                err++; $display("FAIL three_commit%0d got %0b/%05h/%02h expected 1/%05h/%02h", i, mem_we, mem_addr, mem_wdata, ea[i], ed[i]); end
        end
        @(negedge clk_tb);
        vec++; if (mem_we !== 1'b0 || overflow !== 3'b000) begin err++; $display("FAIL three_after got we=%0b ovf=%03b expected 0 000", mem_we, overflow); end
    endtask

    task automatic test_overflow();
        int sum;
        do_reset();
        for (int c = 0; c < 42; c++) begin
            if (c < 12) drive(3'b111, 16'(c), 16'(16 + c), 16'(32 + c), 8'(c), 8'(c + 64), 8'(c + 128));
            else        drive(3'b000, 16'h0, 16'h0, 16'h0, 8'h0, 8'h0, 8'h0);
            @(negedge clk_tb);
            vec++; if (mem_we !== m_we) begin err++; $display("FAIL ovf_mem_we cycle %0d got %0b expected %0b", c, mem_we, m_we); end
            if (m_we) begin vec++; if (mem_addr !== m_addr || mem_wdata !== m_data) begin
                err++; $display("FAIL ovf_write cycle %0d got %05h/%02h expected %05h/%02h", c, mem_addr, mem_wdata, m_addr, m_data); end end
            vec++; if (overflow !== m_ovf) begin err++; $display("FAIL ovf_flags cycle %0d got %03b expected %03b", c, overflow, m_ovf); end
            vec++; if (busy !== model_busy()) begin err++; $display("FAIL ovf_busy cycle %0d got %0b expected %0b", c, busy, model_busy()); end
        end
        sum = int'(commit_cnt_0) + int'(commit_cnt_1) + int'(commit_cnt_2);
        vec++; if (sum !== 36 - m_drops || m_drops == 0) begin err++; $display("FAIL ovf_total got %0d commits expected %0d (drops %0d)", sum, 36 - m_drops, m_drops); end
    endtask

    task automatic test_full_with_pop();
        logic [2:0] w;
        int fwp = 0;
        int pushed1 = 0;
        int g;
        do_reset();
        for (int c = 0; c < 65; c++) begin
            g = pick();
            for (int k = 0; k < 3; k++) w[k] = (c < 36) && ((mq[k].size() < DEPTH) || (g == k));
            if (w[1] && mq[1].size() == DEPTH && g == 1) fwp++;
            if (w[1]) pushed1++;
            drive(w, 16'(100 + c), 16'(200 + c), 16'(300 + c), 8'(c), 8'(c + 64), 8'(c + 128));
            @(negedge clk_tb);
            vec++; if (mem_we !== m_we) begin err++; $display("FAIL fwp_mem_we cycle %0d got %0b expected %0b", c, mem_we, m_we); end
            if (m_we) begin vec++; if (mem_addr !== m_addr || mem_wdata !== m_data) begin
                err++; $display("FAIL fwp_write cycle %0d got %05h/%02h expected %05h/%02h", c, mem_addr, mem_wdata, m_addr, m_data); end end
            vec++; if (overflow !== 3'b000) begin err++; $display("FAIL fwp_overflow cycle %0d got %03b expected 000", c, overflow); end
        end
        vec++; if (fwp == 0) begin err++; $display("FAIL fwp_setup got 0 full-with-pop pushes expected >0"); end
        vec++; if (commit_cnt_1 !== 17'(pushed1)) begin err++; $display("FAIL fwp_cnt1 got %0d expected %0d", commit_cnt_1, pushed1); end
    endtask

    task automatic test_random();
        logic [2:0] w;
        int p;
        do_reset();
        for (int c = 0; c < 300; c++) begin
            p = (c < 120) ? 30 : 55;
            for (int k = 0; k < 3; k++) w[k] = (c < 240) && ($urandom_range(0, 99) < p);
            drive(w, 16'($urandom), 16'($urandom), 16'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            @(negedge clk_tb);
            vec++; if (mem_we !== m_we) begin err++; $display("FAIL rand_mem_we cycle %0d got %0b expected %0b", c, mem_we, m_we); end
            if (m_we) begin vec++; if (mem_addr !== m_addr || mem_wdata !== m_data) begin
                err++; $display("FAIL rand_write cycle %0d got %05h/%02h expected %05h/%02h", c, mem_addr, mem_wdata, m_addr, m_data); end end
            vec++; if (overflow !== m_ovf) begin err++; $display("FAIL rand_overflow cycle %0d got %03b expected %03b", c, overflow, m_ovf); end
            vec++; if (busy !== model_busy() || done !== m_done) begin
                err++; $display("FAIL rand_busy_done cycle %0d got %0b%0b expected %0b%0b", c, busy, done, model_busy(), m_done); end
        end
        vec++; if (commit_cnt_0 !== 17'(m_cnt[0]) || commit_cnt_1 !== 17'(m_cnt[1]) || commit_cnt_2 !== 17'(m_cnt[2])) begin
            err++; $display("FAIL rand_counts got %0d %0d %0d expected %0d %0d %0d", commit_cnt_0, commit_cnt_1, commit_cnt_2, m_cnt[0], m_cnt[1], m_cnt[2]); end
`ifdef RESULT_CHECKSUM_EN
        vec++; if (checksum_0 !== m_csum[0] || checksum_1 !== m_csum[1] || checksum_2 !== m_csum[2]) begin
            err++; $display("FAIL rand_checksum got %04h %04h %04h expected %04h %04h %04h", checksum_0, checksum_1, checksum_2, m_csum[0], m_csum[1], m_csum[2]); end
`endif
    endtask

    task automatic test_done();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(3'(1 << (i % 3)), 16'(i), 16'(i), 16'(i), 8'(i), 8'(i), 8'(i));
            @(negedge clk_tb);
            vec++; if (done !== 1'b0) begin err++; $display("FAIL done_early write %0d got %0b expected 0", i, done); end
            vec++; if (mem_we !== m_we) begin err++; $display("FAIL done_mem_we write %0d got %0b expected %0b", i, mem_we, m_we); end
        end
        for (int i = 0; i < 5; i++) begin
            drive(3'b000, 16'h0, 16'h0, 16'h0, 8'h0, 8'h0, 8'h0);
            @(negedge clk_tb);
            vec++; if (done !== m_done) begin err++; $display("FAIL done_rise idle %0d got %0b expected %0b", i, done, m_done); end
        end
        vec++; if (done !== 1'b1) begin err++; $display("FAIL done_set got %0b expected 1", done); end
        for (int i = 0; i < 6; i++) begin
            if (i < 3) drive(3'(1 << i), 16'h40, 16'h41, 16'h42, 8'h7E, 8'h7E, 8'h7E);
            else       drive(3'b000, 16'h0, 16'h0, 16'h0, 8'h0, 8'h0, 8'h0);
            @(negedge clk_tb);
            vec++; if (done !== 1'b1) begin err++; $display("FAIL done_sticky cycle %0d got %0b expected 1", i, done); end
        end
        vec++; if (commit_cnt_0 !== 17'd5 || commit_cnt_2 !== 17'd5) begin
            err++; $display("FAIL done_post_cnt got %0d %0d expected 5 5", commit_cnt_0, commit_cnt_2); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        drive(3'b111, 16'h10, 16'h20, 16'h30, 8'h01, 8'h02, 8'h03);
        @(negedge clk_tb);
        drive(3'b111, 16'h11, 16'h21, 16'h31, 8'h04, 8'h05, 8'h06);
        @(negedge clk_tb);
        vec++; if (busy !== 1'b1 || mem_we !== 1'b1) begin err++; $display("FAIL mid_pending got busy=%0b we=%0b expected 1 1", busy, mem_we); end
        drive(3'b000, 16'h0, 16'h0, 16'h0, 8'h0, 8'h0, 8'h0);
        rst = 1'b0;
        @(negedge clk_tb);
        rst = 1'b1;
        vec++; if (mem_we !== 1'b0 || overflow !== 3'b000 || done !== 1'b0 || busy !== 1'b0) begin
            err++; $display("FAIL mid_reset got we=%0b ovf=%03b done=%0b busy=%0b expected 0 000 0 0", mem_we, overflow, done, busy); end
        vec++; if ({commit_cnt_0, commit_cnt_1, commit_cnt_2} !== '0) begin
            err++; $display("FAIL mid_counts got %0d %0d %0d expected 0 0 0", commit_cnt_0, commit_cnt_1, commit_cnt_2); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_tb);
            vec++; if (mem_we !== 1'b0) begin err++; $display("FAIL mid_discard cycle %0d got we=%0b expected 0", i, mem_we); end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_three();
        test_overflow();
        test_full_with_pop();
        test_random();
        test_done();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/pool_result_collector.md
Name: pool_result_collector

Overview:
Memory-side responder for the three conv_pool result write channels (output_we_k / output_addr_k / y_k).
- Accepts up to three result bytes per cycle into per-channel FIFOs.
- Arbitrates them round-robin onto one single-port result SRAM write port.
- Tracks per-channel commit counts, overflow and completion.
- Sits between conv_pool and the result memory; replaces the three independent write models.

Parameters:
DEPTH, 8, entries per channel FIFO (power of 2, >=2)
EXPECTED, 65536, results per channel that constitute a complete frame
CNT_W, 17, width of per-channel commit counters (must hold EXPECTED)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-low reset
we_0, we_1, we_2  in  1 each  result write strobe from conv_pool channel k
addr_0, addr_1, addr_2  in  16 each  result address, channel k
y_0, y_1, y_2  in  8 each  result byte, channel k
mem_we  out  1  SRAM write enable
mem_addr  out  18  SRAM address {channel[1:0], addr[15:0]}
mem_wdata  out  8  SRAM write data
overflow  out  3  sticky per-channel drop flag
busy  out  1  any FIFO non-empty or mem_we high
done  out  1  sticky frame-complete flag
commit_cnt_0, commit_cnt_1, commit_cnt_2  out  CNT_W each  results committed per channel

Behaviour:
- Reset (rst==0 at an edge): FIFOs flushed, pointers 0, all outputs 0, round-robin pointer at channel 0. Takes priority over every in-flight write. Entries pending at reset are discarded, not committed.
- Push: we_k==1 at edge N stores {addr_k, y_k} (24 bits) in FIFO k.
  - If FIFO k is full and not popped that cycle, the entry is dropped and overflow[k] sets; it stays set until reset.
  - Full with a simultaneous pop: the push is accepted and no overflow is flagged.
- Arbiter: each cycle, if any FIFO is non-empty, grant exactly one channel.
  - Search order starts at (last_grant+1) mod 3 and skips empty FIFOs.
  - The granted FIFO pops at the edge.
- Output register: on the pop edge, load mem_we=1, mem_addr={k,addr}, mem_wdata=data. mem_we is 0 in any cycle with no grant.
- Latency: a push at edge N to an empty FIFO with no competing channels gives mem_we high in the cycle after edge N+1.
- Throughput: 1 commit/cycle aggregate. Sustained three-channel input overflows by design.
- Ordering: per-channel order preserved. Cross-channel order is round-robin only.
- commit_cnt_k increments on the edge where channel k's entry is registered to the output. Saturates at 2^CNT_W-1.
- done: sets once every commit_cnt_k >= EXPECTED, all FIFOs are empty and mem_we==0. Sticky until reset. Pushes after done are still accepted and committed.
- busy is combinational from FIFO empties and mem_we.
- Address wrap: addr is passed through unchanged; duplicate addresses simply overwrite in SRAM.

Optional Feature:
RESULT_CHECKSUM_EN:
- When defined: adds ports checksum_0/1/2 (out, 16 each).
  - Each is a modulo-2^16 running sum of committed data bytes for channel k, updated on the same edge as commit_cnt_k.
  - Reset to 0.
- When undefined: the ports and adders are absent and behaviour is otherwise identical.

Decomposition:
- Package conv_pool_pkg holds:
  - NUM_CH=3, ADDR_W=16, DATA_W=8
  - typedef result_entry_t, a packed struct {addr, data}
  - typedef ch_idx_t (2 bits)
- Sub-module result_fifo: synchronous FIFO parameterised by DEPTH and entry type.
  - Ports: push, pop, din, dout (show-ahead), full, empty.
  - Same-cycle push/pop when full is allowed.
  - Instantiated three times.

Test Plan:
- Single write: reset, then we_0=1, addr_0=16'h0005, y_0=8'hA5 for one cycle -> one cycle later mem_we=1, mem_addr=18'h00005, mem_wdata=8'hA5; commit_cnt_0=1; busy drops after.
- Simultaneous three: we_0/1/2 in one cycle with addrs 1/2/3 and data 11/22/33 -> three consecutive commits in order ch0, ch1, ch2 (mem_addr 18'h00001, 18'h10002, 18'h20003); no overflow.
- Overflow: DEPTH=8, all three channels write every cycle for 12 cycles -> overflow==3'b111 or a subset depending on drain; total commits = 36 - drops; per-channel data order strictly increasing with no gaps except dropped entries.
- Full with pop: fill FIFO 1 to 8 while it is being granted, push on the grant edge -> no overflow[1]; entry committed.
- Done: EXPECTED=4, four writes per channel interleaved -> done rises only after the 12th commit and empty FIFOs; further writes keep done=1.
- Reset mid-burst: 5 entries queued, rst=0 for one edge -> next cycle mem_we=0, all counts 0, overflow 0, done 0; queued entries are never written.
